muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide controller beside the EXE-stage ALU. Owns the HI/LO pair.

---
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Shift-add multiply and restoring divide, one radix-2 step per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;

  logic             idle_like, accept, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // rem_q/quo_q double as the upper/lower halves of the multiply product register
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    accept    = idle_like && start_i && !flush_i;
    a_neg     = ~op_i[0] & operand_a_i[WIDTH-1];
    b_neg     = ~op_i[0] & operand_b_i[WIDTH-1];
    a_mag     = a_neg ? (~operand_a_i + ONE_W) : operand_a_i;
    b_mag     = b_neg ? (~operand_b_i + ONE_W) : operand_b_i;
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    prod      = {rem_q, quo_q};
    prod_fix  = neg_q ? (~prod + ONE_2W) : prod;
    quot_fix  = neg_q ? (~quo_q + ONE_W) : quo_q;
    rem_fix   = rneg_q ? (~rem_q + ONE_W) : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          dbz_d    = 1'b0;
          is_div_d = op_i[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          rem_d    = '0;
          cnt_d    = CW'(WIDTH);
          opb_d    = op_i[1] ? b_mag : a_mag;
          quo_d    = op_i[1] ? a_mag : b_mag;
          if (op_i[1] && (operand_b_i == '0)) begin
            hi_d    = operand_a_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end else if (!start_i) begin
          if (mthi_i) hi_d = operand_a_i;
          if (mtlo_i) lo_d = operand_a_i;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
          end else begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_CALC) || (state_q == S_FIX);
  assign stall_o       = busy_o || (start_i && idle_like);
  assign done_o        = (state_q == S_DONE);
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed vector bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done, dbz;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .operand_a_i(a), .operand_b_i(b), .mthi_i(mthi), .mtlo_i(mtlo),
    .flush_i(flush), .stall_o(stall), .busy_o(busy), .done_o(done),
    .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // waits for done starting from cycle `first`; returns cycle of done or -1
  task automatic wait_done(input int first, output int cyc_out, output int gap);
    int cyc;
    bit got;
    cyc = first; got = 0; gap = 0;
    while (cyc <= 80 && !got) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        if (!stall) gap++;
        cyc++;
      end
    end
    cyc_out = got ? cyc : -1;
  endtask

  initial begin
    int cyc, gap;
    bit seen;
    logic [31:0] prev_hi, prev_lo;

    rst = 1; start = 0; mthi = 0; mtlo = 0; flush = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_flags", {stall, busy, done, dbz}, 0);

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34};
    vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[7]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 34};
    vecs[10] = '{2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1};
    vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 start = 1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      check($sformatf("v%0d_stall_c0", i), stall, 1);
      check($sformatf("v%0d_busy_c0", i), busy, 0);
      @(posedge clk);
      #1 start = 0;
      wait_done(1, cyc, gap);
      check($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      check($sformatf("v%0d_stall_gap", i), gap, 0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
      check($sformatf("v%0d_stall_done", i), stall, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_hold", i), {hi, lo, 31'b0, dbz}, {vecs[i].hi, vecs[i].lo, 31'b0, vecs[i].dbz});
    end
    prev_hi = vecs[11].hi;
    prev_lo = vecs[11].lo;

    // flush a MULT at cycle 10
    @(posedge clk);
    #1 start = 1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush_c10_busy", busy, 1);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush_c11_flags", {stall, busy, done}, 0);
    check("flush_hilo", {hi, lo}, {prev_hi, prev_lo});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("flush_no_done", seen, 0);

    // direct HI/LO writes
    @(posedge clk);
    #1 mthi = 1; a = 32'hA5A5A5A5;
    @(posedge clk);
    #1 mthi = 0; mtlo = 1; a = 32'h5A5A5A5A;
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mthi_lo_kept", lo, prev_lo);
    @(posedge clk);
    #1 mtlo = 0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5A5A5A5A);

    // reset in cycle 20 of a DIV
    @(posedge clk);
    #1 start = 1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 0;
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_mid_hilo", {hi, lo}, 0);
    check("rst_mid_flags", {stall, busy, done, dbz}, 0);

    // mthi coinciding with start, plus a start while busy
    @(posedge clk);
    #1 mthi = 1; start = 1; op = 2'b11; a = 32'hA5A5A5A5; b = 32'h10;
    @(negedge clk);
    check("mthi_start_stall", stall, 1);
    @(posedge clk);
    #1 mthi = 0; start = 0;
    @(negedge clk);
    check("mthi_dropped", hi, 0);
    check("start_busy", busy, 1);
    repeat (4) @(posedge clk);
    #1 start = 1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    wait_done(6, cyc, gap);
    check("busy_start_latency", cyc, 34);
    check("busy_start_hi", hi, 32'h00000005);
    check("busy_start_lo", lo, 32'h0A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
